io_hub: RTL and testbench
=========================

// Module: io_hub
// PURPOSE
// Parametrised memory-mapped I/O peripheral for the single-cycle core, next generation of the UI controller.
// Sits behind the IO address decoder on the load/store path and drives HEX/LEDR from the core's writes.
// Adds debounced key/switch inputs, a sticky key-event status register and a programmable interval timer.
// Generalises the fixed 4-key/10-switch/4-digit UI to parametrised widths and digit count.
// PARAMETERS
// DBITS      32            data/address width
// NKEYS      4             key inputs (pins active-low)
// NSW        10            switch inputs
// NLEDR      10            red LED outputs
// NHEX       4             7-segment digits; HEX register uses low 4*NHEX bits
// DEB_CYC    16'd50000     consecutive stable samples required to accept a new key/switch level
// TICK_CYC   32'd100000    clk cycles per timer tick (1 ms at 100 MHz)
// ADDR_HEX 32'hF0000000, ADDR_LEDR 32'hF0000004, ADDR_KEY 32'hF0000010, ADDR_SW 32'hF0000014,
// ADDR_TCNT 32'hF0000020, ADDR_TLIM 32'hF0000024, ADDR_KCTL 32'hF0000110, ADDR_TCTL 32'hF0000120
// PORTS
// clk      in   1          core clock
// reset_n  in   1          reset, asynchronous, active-low
// addr     in   DBITS      byte address of access
// wr_en    in   1          write strobe, sampled on rising clk
// wdata    in   DBITS      write data
// rdata    out  DBITS      read data, combinational from addr
// KEY      in   NKEYS      raw key pins, 0 = pressed
// SW       in   NSW        raw switch pins
// LEDR     out  NLEDR      LED register
// HEX      out  7*NHEX     segments, digit i at [7i+6:7i], active-low
// BEHAVIOUR
// - Reset (reset_n=0, async): HEX reg, LEDR, TCNT, TLIM, prescaler, all status bits, sync FFs, debounced
//   levels and debounce counters = 0; HEX outputs = 7'b1000000 per digit ("0"); rdata follows addr.
// - Inputs: each KEY/SW bit passes 2-FF synchroniser; KEY inverted (pressed=1). Per bit a debounce counter
//   counts cycles where synced != debounced level, clears when equal; at DEB_CYC-1 the level flips, counter clears.
//   Latency raw pin -> debounced = 2 + DEB_CYC cycles.
// - KEY read: debounced pressed levels, zero-extended. SW read: debounced switch levels, zero-extended.
// - Key event = any debounced key 0->1 this cycle. KCTL bit0 ready, bit2 overrun; other bits read 0.
//   Write to KCTL: bit0=0 clears ready, bit2=0 clears overrun; writing 1 never sets.
//   ready_nxt = ev | (ready & ~clr_rdy); ovr_nxt = (ev & ready & ~clr_rdy) | (ovr & ~clr_ovr). Event wins over clear.
// - HEX: write stores wdata[4*NHEX-1:0]; each nibble decoded 0-F to standard active-low 7-seg (A=7'b0001000).
// - LEDR: write stores wdata[NLEDR-1:0]; LEDR output = register directly.
// - Timer: TLIM==0 -> stopped, prescaler and TCNT hold. Else prescaler counts 0..TICK_CYC-1 then wraps;
//   on wrap TCNT increments; if TCNT==TLIM-1 it wraps to 0 and sets TCTL ready (overrun if ready already 1).
//   TCTL bits/clear rules identical to KCTL. Write TCNT loads wdata and clears prescaler; write wins over tick.
//   Write TLIM loads wdata; TCNT >= new TLIM counts up through 2^DBITS-1 and wraps to 0 (no ready at wrap).
// - Reads: combinational, no side effects; unmapped address -> 0. Writes to KEY/SW/unmapped ignored.
// - Reset mid-debounce or mid-count: all state returns to reset values immediately; no event generated.
// TESTING
// - Reset: hold reset_n=0, toggle clk -> LEDR=0, HEX=4x7'b1000000, read TCNT/KCTL/TCTL=0.
// - Debounce (DEB_CYC=4): KEY[1] 1->0 with 3-cycle glitch -> no change; held 6+ cycles -> KEY read 0x2, KCTL=1.
// - Overrun: two presses without clear -> KCTL=0x5; write KCTL 0 -> 0; clear in same cycle as press -> KCTL=1.
// - Timer (TICK_CYC=3): TLIM=2 -> TCNT 0,1,0 every 3 cycles, TCTL=1 after 6 cycles; TLIM=0 freezes TCNT.
// - HEX/LEDR: write HEX 0x0000A3F5 (NHEX=4) -> digits 5,F,3,A; write LEDR 0x3FF -> all LEDs on.
// - Unmapped read 0xF0000030 -> 0; write TCNT=7 same cycle as tick -> TCNT=7, prescaler=0.

Source files
------------

// File: rtl/io_hub_if.sv
// Load/store bus between the core's IO address decoder and io_hub.
// Ports: addr/wr_en/wdata driven by the core (master), rdata returned
// combinationally by the peripheral (slave).
interface io_hub_if #(
  parameter int DBITS = 32
) ();
  logic [DBITS-1:0] addr;
  logic             wr_en;
  logic [DBITS-1:0] wdata;
  logic [DBITS-1:0] rdata;

  modport master (output addr, output wr_en, output wdata, input rdata);
  modport slave  (input addr, input wr_en, input wdata, output rdata);
endinterface

// File: rtl/io_hub.sv
// Memory-mapped UI peripheral: HEX/LEDR output registers, debounced KEY/SW inputs,
// sticky key-event status (KCTL) and a programmable interval timer (TCNT/TLIM/TCTL).
// Ports: clk, reset_n (async active-low), bus (slave: addr/wr_en/wdata in, rdata out,
// reads combinational), KEY (active-low pins), SW, LEDR, HEX (active-low 7-seg per digit).
module io_hub #(
  parameter int              DBITS     = 32,
  parameter int              NKEYS     = 4,
  parameter int              NSW       = 10,
  parameter int              NLEDR     = 10,
  parameter int              NHEX      = 4,
  parameter logic [15:0]     DEB_CYC   = 16'd50000,
  parameter logic [31:0]     TICK_CYC  = 32'd100000,
  parameter logic [DBITS-1:0] ADDR_HEX  = 32'hF0000000,
  parameter logic [DBITS-1:0] ADDR_LEDR = 32'hF0000004,
  parameter logic [DBITS-1:0] ADDR_KEY  = 32'hF0000010,
  parameter logic [DBITS-1:0] ADDR_SW   = 32'hF0000014,
  parameter logic [DBITS-1:0] ADDR_TCNT = 32'hF0000020,
  parameter logic [DBITS-1:0] ADDR_TLIM = 32'hF0000024,
  parameter logic [DBITS-1:0] ADDR_KCTL = 32'hF0000110,
  parameter logic [DBITS-1:0] ADDR_TCTL = 32'hF0000120
) (
  input  logic               clk,
  input  logic               reset_n,
  io_hub_if.slave            bus,
  input  logic [NKEYS-1:0]   KEY,
  input  logic [NSW-1:0]     SW,
  output logic [NLEDR-1:0]   LEDR,
  output logic [7*NHEX-1:0]  HEX
);

  // Keys and switches share one synchroniser/debounce array; keys occupy the low bits.
  localparam int NIN = NKEYS + NSW;

  logic [NIN-1:0]    raw, sync1, sync2, deb, deb_nxt, flip;
  logic [15:0]       cnt [NIN];
  logic [4*NHEX-1:0] hex_reg;
  logic [NLEDR-1:0]  ledr_reg;
  logic [DBITS-1:0]  tcnt, tlim, rdata;
  logic [31:0]       presc;
  logic              k_rdy, k_ovr, t_rdy, t_ovr;
  logic              wr_hex, wr_ledr, wr_tcnt, wr_tlim, wr_kctl, wr_tctl;
  logic              k_clr_rdy, k_clr_ovr, t_clr_rdy, t_clr_ovr;
  logic              key_ev, t_ev, run, presc_wrap, tcnt_last;

  // Pressed keys become 1 before synchronisation so reset (all 0) means "released".
  assign raw = {SW, ~KEY};

  assign wr_hex  = bus.wr_en && (bus.addr == ADDR_HEX);
  assign wr_ledr = bus.wr_en && (bus.addr == ADDR_LEDR);
  assign wr_tcnt = bus.wr_en && (bus.addr == ADDR_TCNT);
  assign wr_tlim = bus.wr_en && (bus.addr == ADDR_TLIM);
  assign wr_kctl = bus.wr_en && (bus.addr == ADDR_KCTL);
  assign wr_tctl = bus.wr_en && (bus.addr == ADDR_TCTL);

  // Writing 0 to a status bit clears it; writing 1 leaves it alone.
  assign k_clr_rdy = wr_kctl && !bus.wdata[0];
  assign k_clr_ovr = wr_kctl && !bus.wdata[2];
  assign t_clr_rdy = wr_tctl && !bus.wdata[0];
  assign t_clr_ovr = wr_tctl && !bus.wdata[2];

  always_comb begin
    deb_nxt = deb;
    flip    = '0;
    for (int i = 0; i < NIN; i++) begin
      flip[i] = (sync2[i] != deb[i]) && (cnt[i] == DEB_CYC - 16'd1);
      if (flip[i]) deb_nxt[i] = ~deb[i];
    end
  end

  assign key_ev = |(deb_nxt[NKEYS-1:0] & ~deb[NKEYS-1:0]);

  // A TCNT write overrides the tick in the same cycle, including any wrap event.
  assign run        = (tlim != '0);
  assign presc_wrap = run && (presc == TICK_CYC - 32'd1);
  assign tcnt_last  = (tcnt == tlim - DBITS'(1));
  assign t_ev       = presc_wrap && tcnt_last && !wr_tcnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1    <= '0;
      sync2    <= '0;
      deb      <= '0;
      for (int i = 0; i < NIN; i++) cnt[i] <= '0;
      hex_reg  <= '0;
      ledr_reg <= '0;
      tcnt     <= '0;
      tlim     <= '0;
      presc    <= '0;
      k_rdy    <= 1'b0;
      k_ovr    <= 1'b0;
      t_rdy    <= 1'b0;
      t_ovr    <= 1'b0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb   <= deb_nxt;
      for (int i = 0; i < NIN; i++) begin
        if ((sync2[i] == deb[i]) || flip[i]) cnt[i] <= '0;
        else                                 cnt[i] <= cnt[i] + 16'd1;
      end

      if (wr_hex)  hex_reg  <= bus.wdata[4*NHEX-1:0];
      if (wr_ledr) ledr_reg <= bus.wdata[NLEDR-1:0];
      if (wr_tlim) tlim     <= bus.wdata;

      if (wr_tcnt) begin
        tcnt  <= bus.wdata;
        presc <= '0;
      end else if (presc_wrap) begin
        presc <= '0;
        tcnt  <= tcnt_last ? '0 : tcnt + DBITS'(1);
      end else if (run) begin
        presc <= presc + 32'd1;
      end

      // Event beats a simultaneous clear.
      k_rdy <= key_ev | (k_rdy & ~k_clr_rdy);
      k_ovr <= (key_ev & k_rdy & ~k_clr_rdy) | (k_ovr & ~k_clr_ovr);
      t_rdy <= t_ev | (t_rdy & ~t_clr_rdy);
      t_ovr <= (t_ev & t_rdy & ~t_clr_rdy) | (t_ovr & ~t_clr_ovr);
    end
  end

  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'h0: seg7 = 7'b1000000;  4'h1: seg7 = 7'b1111001;
      4'h2: seg7 = 7'b0100100;  4'h3: seg7 = 7'b0110000;
      4'h4: seg7 = 7'b0011001;  4'h5: seg7 = 7'b0010010;
      4'h6: seg7 = 7'b0000010;  4'h7: seg7 = 7'b1111000;
      4'h8: seg7 = 7'b0000000;  4'h9: seg7 = 7'b0010000;
      4'hA: seg7 = 7'b0001000;  4'hB: seg7 = 7'b0000011;
      4'hC: seg7 = 7'b1000110;  4'hD: seg7 = 7'b0100001;
      4'hE: seg7 = 7'b0000110;  default: seg7 = 7'b0001110;
    endcase
  endfunction

  always_comb begin
    HEX = '0;
    for (int i = 0; i < NHEX; i++) HEX[7*i +: 7] = seg7(hex_reg[4*i +: 4]);
  end

  assign LEDR = ledr_reg;

  always_comb begin
    rdata = '0;
    case (bus.addr)
      ADDR_HEX:  rdata = DBITS'(hex_reg);
      ADDR_LEDR: rdata = DBITS'(ledr_reg);
      ADDR_KEY:  rdata = DBITS'(deb[NKEYS-1:0]);
      ADDR_SW:   rdata = DBITS'(deb[NIN-1:NKEYS]);
      ADDR_TCNT: rdata = tcnt;
      ADDR_TLIM: rdata = tlim;
      ADDR_KCTL: rdata = DBITS'({k_ovr, 1'b0, k_rdy});
      ADDR_TCTL: rdata = DBITS'({t_ovr, 1'b0, t_rdy});
      default:   rdata = '0;
    endcase
  end

  assign bus.rdata = rdata;

endmodule

// File: tb/tb_io_hub.sv
// Bench for io_hub with DEB_CYC=4, TICK_CYC=3: register table, debounce/status
// sequences, timer corner cases and a randomized timer/register run against a
// counting model.
module tb_io_hub;
  localparam logic [31:0] A_HEX  = 32'hF0000000, A_LEDR = 32'hF0000004;
  localparam logic [31:0] A_KEY  = 32'hF0000010, A_SW   = 32'hF0000014;
  localparam logic [31:0] A_TCNT = 32'hF0000020, A_TLIM = 32'hF0000024;
  localparam logic [31:0] A_KCTL = 32'hF0000110, A_TCTL = 32'hF0000120;
  localparam logic [27:0] HEX_ZERO = 28'b1000000_1000000_1000000_1000000;
  localparam logic [27:0] HEX_A3F5 = 28'b0001000_0110000_0001110_0010010;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [3:0]  KEY = 4'hF;
  logic [9:0]  SW = '0;
  logic [9:0]  LEDR;
  logic [27:0] HEX;
  int          n_cmp = 0;
  int          n_bad = 0;

  io_hub_if #(.DBITS(32)) bus ();

  io_hub #(.DEB_CYC(16'd4), .TICK_CYC(32'd3)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus),
    .KEY(KEY), .SW(SW), .LEDR(LEDR), .HEX(HEX)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          wr;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic [31:0] raddr;
    logic [31:0] exp;
    string       name;
  } vec_t;

  vec_t vt[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Drive a write for one rising edge; returns 1 time unit after that edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    bus.addr  = a;
    bus.wdata = d;
    bus.wr_en = 1'b1;
    @(posedge clk);
    #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [31:0] a, output logic [31:0] d);
    bus.addr = a;
    #1;
    d = bus.rdata;
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] got, d;
    int L, s, n, total;

    bus.addr = '0; bus.wdata = '0; bus.wr_en = 1'b0;

    // Reset state while held in reset
    repeat (3) @(posedge clk);
    #1;
    check("rst_ledr", 32'(LEDR), 32'h0);
    check("rst_hex", 32'(HEX), 32'(HEX_ZERO));
    rd(A_TCNT, got); check("rst_tcnt", got, 32'h0);
    rd(A_KCTL, got); check("rst_kctl", got, 32'h0);
    rd(A_TCTL, got); check("rst_tctl", got, 32'h0);
    reset_n = 1'b1;
    cycles(2);

    // Register table
    vt[0] = '{1'b1, A_HEX,  32'hFFFFFFFF, A_HEX,  32'h0000FFFF, "hex_mask"};
    vt[1] = '{1'b1, A_LEDR, 32'h00000155, A_LEDR, 32'h00000155, "ledr_155"};
    vt[2] = '{1'b1, A_LEDR, 32'hFFFFFFFF, A_LEDR, 32'h000003FF, "ledr_all"};
    vt[3] = '{1'b1, A_KEY,  32'h00000055, A_KEY,  32'h00000000, "key_ro"};
    vt[4] = '{1'b1, A_SW,   32'h000003FF, A_SW,   32'h00000000, "sw_ro"};
    vt[5] = '{1'b1, 32'hF0000030, 32'h0000DEAD, 32'hF0000030, 32'h0, "unmapped"};
    vt[6] = '{1'b1, A_TLIM, 32'h12345678, A_TLIM, 32'h12345678, "tlim_rw"};
    vt[7] = '{1'b1, A_TLIM, 32'h00000000, A_TLIM, 32'h00000000, "tlim_zero"};
    vt[8] = '{1'b1, A_HEX,  32'h0000A3F5, A_HEX,  32'h0000A3F5, "hex_a3f5"};
    vt[9] = '{1'b0, 32'h0,  32'h0,        32'hF0000008, 32'h0, "unmapped2"};
    for (int i = 0; i < 10; i++) begin
      if (vt[i].wr) wr(vt[i].waddr, vt[i].wdata);
      rd(vt[i].raddr, got);
      check(vt[i].name, got, vt[i].exp);
    end
    check("hex_pins", 32'(HEX), 32'(HEX_A3F5));
    check("ledr_pins", 32'(LEDR), 32'h3FF);

    // Debounce: 3-cycle glitch on KEY[1] must be rejected
    @(posedge clk); #1;
    KEY[1] = 1'b0;
    cycles(3);
    KEY[1] = 1'b1;
    cycles(8);
    rd(A_KEY, got);  check("glitch_key", got, 32'h0);
    rd(A_KCTL, got); check("glitch_kctl", got, 32'h0);

    // Held press: accepted exactly 2+DEB_CYC edges after the pin change
    @(posedge clk); #1;
    KEY[1] = 1'b0;
    cycles(5);
    rd(A_KEY, got);  check("press_early", got, 32'h0);
    cycles(1);
    rd(A_KEY, got);  check("press_key", got, 32'h2);
    rd(A_KCTL, got); check("press_kctl", got, 32'h1);

    // Release is not an event; a second press overruns
    KEY[1] = 1'b1;
    cycles(8);
    rd(A_KEY, got);  check("release_key", got, 32'h0);
    rd(A_KCTL, got); check("release_kctl", got, 32'h1);
    KEY[1] = 1'b0;
    cycles(8);
    rd(A_KCTL, got); check("overrun_kctl", got, 32'h5);
    wr(A_KCTL, 32'h0);
    rd(A_KCTL, got); check("kctl_clear", got, 32'h0);

    // Clear in the same cycle as the press event: event wins
    KEY[1] = 1'b1;
    cycles(8);
    @(posedge clk); #1;
    KEY[1] = 1'b0;
    cycles(5);
    wr(A_KCTL, 32'h0);
    rd(A_KEY, got);  check("race_key", got, 32'h2);
    rd(A_KCTL, got); check("race_kctl", got, 32'h1);

    // Switch debounce
    SW = 10'h2A5;
    cycles(8);
    rd(A_SW, got); check("sw_level", got, 32'h2A5);

    // Timer: TLIM=2 -> 0,1,0 every 3 cycles, ready on wrap
    wr(A_TLIM, 32'h0); wr(A_TCTL, 32'h0); wr(A_TCNT, 32'h0); wr(A_TLIM, 32'h2);
    cycles(3);
    rd(A_TCNT, got); check("tmr_tcnt1", got, 32'h1);
    rd(A_TCTL, got); check("tmr_tctl0", got, 32'h0);
    cycles(3);
    rd(A_TCNT, got); check("tmr_tcnt0", got, 32'h0);
    rd(A_TCTL, got); check("tmr_tctl1", got, 32'h1);
    wr(A_TLIM, 32'h0);
    cycles(10);
    rd(A_TCNT, got); check("tmr_frozen", got, 32'h0);

    // TCNT write coincident with a tick, then prescaler restart
    wr(A_TCNT, 32'h0); wr(A_TLIM, 32'd100);
    cycles(2);
    wr(A_TCNT, 32'd7);
    rd(A_TCNT, got); check("tcnt_wr_tick", got, 32'd7);
    wr(A_TCNT, 32'd20);
    cycles(2);
    rd(A_TCNT, got); check("presc_clr_a", got, 32'd20);
    cycles(1);
    rd(A_TCNT, got); check("presc_clr_b", got, 32'd21);

    // Randomized: timer counted from elapsed ticks, registers masked by width
    for (int it = 0; it < 20; it++) begin
      d = $urandom;
      wr(A_HEX, d);
      rd(A_HEX, got); check("rnd_hex", got, {16'h0, d[15:0]});
      d = $urandom;
      wr(A_LEDR, d);
      check("rnd_ledr", 32'(LEDR), {22'h0, d[9:0]});

      L = int'($urandom_range(1, 5));
      s = int'($urandom_range(0, L - 1));
      n = int'($urandom_range(0, 30));
      wr(A_TLIM, 32'h0); wr(A_TCTL, 32'h0);
      wr(A_TCNT, 32'(s)); wr(A_TLIM, 32'(L));
      cycles(n);
      total = s + n / 3;
      rd(A_TCNT, got); check("rnd_tcnt", got, 32'(total % L));
      rd(A_TCTL, got);
      check("rnd_tctl", got, {29'h0, total >= 2 * L, 1'b0, total >= L});
    end

    // Asynchronous reset mid-count
    wr(A_TLIM, 32'd5);
    cycles(4);
    #2 reset_n = 1'b0;
    #1;
    rd(A_TCNT, got); check("arst_tcnt", got, 32'h0);
    rd(A_SW, got);   check("arst_sw", got, 32'h0);
    check("arst_ledr", 32'(LEDR), 32'h0);
    check("arst_hex", 32'(HEX), 32'(HEX_ZERO));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
